// File: rtl/dds_quad_fold.sv
// Two-stage DDS address generator: phase offset add, then quarter-wave fold
// (or full-table pass-through) for the I channel and a 90-degree-shifted Q channel.
module dds_quad_fold #(
  parameter int PHASE_W = 10,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [PHASE_W-1:0] phase,
  input  logic [PHASE_W-1:0] phase_ofs,
  input  logic               mode,
  input  logic               quad_en,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  addr_i,
  output logic               neg_i,
  output logic [ADDR_W-1:0]  addr_q,
  output logic               neg_q,
  output logic               zc_i
);

  localparam logic [PHASE_W-1:0] QUARTER = {2'b01, {(PHASE_W-2){1'b0}}};

  logic [PHASE_W-1:0] p_sum;
  logic [PHASE_W-1:0] p_i_reg;
  logic [PHASE_W-1:0] p_q_reg;
  logic               mode_reg;
  logic               quad_en_reg;
  logic               v1_reg;

  logic [1:0][PHASE_W-1:0] ch_phase;
  logic [1:0][ADDR_W-1:0]  ch_addr;
  logic [1:0]              ch_neg;
  logic [1:0]              quad_i;

  logic              out_valid_reg;
  logic [ADDR_W-1:0] addr_i_reg;
  logic              neg_i_reg;
  logic [ADDR_W-1:0] addr_q_reg;
  logic              neg_q_reg;
  logic              zc_reg;
  logic [1:0]        prev_quad_reg;
  logic              no_hist_reg;

  assign p_sum = phase + phase_ofs;

  // Stage 1: wrapped phase sum; Q channel leads I by a quarter turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_i_reg     <= '0;
      p_q_reg     <= '0;
      mode_reg    <= 1'b0;
      quad_en_reg <= 1'b0;
      v1_reg      <= 1'b0;
    end else begin
      v1_reg <= in_valid;
      if (in_valid) begin
        p_i_reg     <= p_sum;
        p_q_reg     <= p_sum + QUARTER;
        mode_reg    <= mode;
        quad_en_reg <= quad_en;
      end
    end
  end

  assign ch_phase[0] = p_i_reg;
  assign ch_phase[1] = p_q_reg;
  assign quad_i      = p_i_reg[PHASE_W-1 -: 2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fold
      logic [1:0]        quad;
      logic [ADDR_W-1:0] frac;
      logic [ADDR_W-1:0] full;

      assign quad = ch_phase[gi][PHASE_W-1 -: 2];
      assign frac = ch_phase[gi][PHASE_W-3 -: ADDR_W];
      assign full = ch_phase[gi][PHASE_W-1 -: ADDR_W];

      // Odd quadrants run the table backwards: (2^ADDR_W-1) - a is just ~a.
      assign ch_addr[gi] = mode_reg ? full : (quad[0] ? ~frac : frac);
      assign ch_neg[gi]  = ~mode_reg & quad[1];
    end
  endgenerate

  // Stage 2: outputs move only on a valid stage-1 sample, zc_i is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      addr_i_reg    <= '0;
      neg_i_reg     <= 1'b0;
      addr_q_reg    <= '0;
      neg_q_reg     <= 1'b0;
      zc_reg        <= 1'b0;
      prev_quad_reg <= 2'd0;
      no_hist_reg   <= 1'b1;
    end else begin
      out_valid_reg <= v1_reg;
      zc_reg        <= 1'b0;
      if (v1_reg) begin
        addr_i_reg    <= ch_addr[0];
        neg_i_reg     <= ch_neg[0];
        addr_q_reg    <= quad_en_reg ? ch_addr[1] : '0;
        neg_q_reg     <= quad_en_reg & ch_neg[1];
        zc_reg        <= ~no_hist_reg && (prev_quad_reg == 2'd3) && (quad_i == 2'd0);
        prev_quad_reg <= quad_i;
        no_hist_reg   <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign addr_i    = addr_i_reg;
  assign neg_i     = neg_i_reg;
  assign addr_q    = addr_q_reg;
  assign neg_q     = neg_q_reg;
  assign zc_i      = zc_reg;

endmodule

// File: doc/dds_quad_fold.md
DDS_QUAD_FOLD -- requirements
Module: dds_quad_fold

Interface
REQ-001 SHALL have parameter PHASE_W, default 10, meaning phase word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning LUT address width in bits.
REQ-003 SHALL support only PHASE_W >= ADDR_W+2; any other combination is unsupported.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  phase, phase_ofs, mode and quad_en are valid this cycle.
REQ-007 phase  input  PHASE_W  accumulator phase word.
REQ-008 phase_ofs  input  PHASE_W  phase offset added to phase.
REQ-009 mode  input  1  0 = quarter-wave fold, 1 = full-table pass-through.
REQ-010 quad_en  input  1  enables the Q (cosine) channel.
REQ-011 out_valid  output  1  outputs carry a new result this cycle.
REQ-012 addr_i  output  ADDR_W  I-channel LUT address.
REQ-013 neg_i  output  1  I-channel sample must be negated downstream.
REQ-014 addr_q  output  ADDR_W  Q-channel LUT address.
REQ-015 neg_q  output  1  Q-channel sample must be negated downstream.
REQ-016 zc_i  output  1  I-channel phase wrap detected, qualified by out_valid.

Function
REQ-017 Stage 1 SHALL register p_i = (phase + phase_ofs) mod 2^PHASE_W when in_valid=1.
- Same condition: p_q = (p_i + 2^(PHASE_W-2)) mod 2^PHASE_W.
- Also registered: mode, quad_en, and v1 = in_valid.
REQ-018 Stage 1 registers other than v1 SHALL hold when in_valid=0.
REQ-019 Stage 2 SHALL update outputs only when v1=1 and SHALL set out_valid = v1 every cycle.
- Fixed latency: 2 cycles from in_valid to out_valid.
- Full throughput: one result per cycle.
REQ-020 For each channel, fields SHALL be defined as:
- quadrant q = p[PHASE_W-1:PHASE_W-2]
- a = p[PHASE_W-3:PHASE_W-2-ADDR_W]
- lower bits truncated.
REQ-021 In mode 0, quadrant addressing SHALL be:
- q=0 or 2: addr = a
- q=1 or 3: addr = (2^ADDR_W - 1) - a
- neg = q[1]
REQ-022 In mode 1, addr SHALL be p[PHASE_W-1:PHASE_W-ADDR_W] and neg SHALL be 0.
REQ-023 When stage-1 quad_en=0 with v1=1, addr_q and neg_q SHALL be driven to 0.
REQ-024 zc_i SHALL be 1 with out_valid only when:
- the current I quadrant is 0, and
- the I quadrant of the previous valid result was 3.
- zc_i is 0 in all other cycles.
REQ-025 The previous-quadrant register SHALL update only on v1=1.
- A "no history" flag SHALL suppress zc_i on the first valid result after reset.
REQ-026 Addresses SHALL never exceed 2^ADDR_W - 1.
- Boundaries: a = 0 and a = all-ones map per REQ-021 with no off-by-one.
- Example, defaults: phase 255 -> 255, 256 -> 255, 511 -> 0, 512 -> 0, 1023 -> 0.
REQ-027 Phase addition SHALL wrap modulo 2^PHASE_W with no saturation.
REQ-028 A mode or quad_en change SHALL take effect on the sample it accompanies, with no pipeline flush.

Reset
REQ-029 rst_n=0 SHALL immediately clear all registers, without waiting for clk:
- out_valid=0, addr_i=0, neg_i=0, addr_q=0, neg_q=0, zc_i=0
- v1=0, previous quadrant = 0, no-history flag set.
REQ-030 Reset mid-stream SHALL discard in-flight samples.
- The first out_valid SHALL occur 2 cycles after the first in_valid following release.
REQ-031 Reset release SHALL be synchronised externally; the block applies no reset-release filtering.

Verification
REQ-032 Defaults, mode 0, quad_en=1, ofs 0; phase 0 -> after 2 cycles:
- addr_i=0, neg_i=0
- addr_q=255, neg_q=0.
REQ-033 Defaults, mode 0, phases 300, 600, 1000 back-to-back -> consecutive cycles give:
- addr_i 211 / neg_i 0
- addr_i 88 / neg_i 1
- addr_i 23 / neg_i 1.
REQ-034 phase 1000 with phase_ofs 100 -> p_i = 76, addr_i=76, neg_i=0.
- If the previous valid sample had quadrant 3, zc_i=1.
REQ-035 Sweep phase 0..1023 then 0 again in mode 0:
- zc_i pulses exactly once, on the second 0.
- No pulse on the first sample after reset.
REQ-036 Mode 1, phase 1000 -> addr_i=250, neg_i=0.
- With quad_en=0 -> addr_q=0, neg_q=0.
REQ-037 Reset checks:
- Assert rst_n=0 between clock edges with samples in flight -> all outputs 0 immediately.
- After release, in_valid gaps -> out_valid tracks in_valid delayed by exactly 2 cycles.
- During gaps, outputs hold.
